// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared state encoding and default sizing for the DAC playback reader
package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_PLAY    = 2'd2,
        ST_FINISH  = 2'd3
    } dac_state_e;

    localparam int DEF_ADDR_W     = 24;
    localparam int DEF_LEN_W      = 24;
    localparam int DEF_BURST_LEN  = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_SAMPLE_DIV = 4;
    localparam int UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/dac_sample_fifo.sv
// rtl/dac_sample_fifo.sv - synchronous sample FIFO with occupancy count and show-ahead read
module dac_sample_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    // Pointer and occupancy update; a simultaneous push and pop leaves occupancy unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
        else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
    end

    // Pointer/occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);

endmodule

// File: rtl/dac_playback_reader.sv
// rtl/dac_playback_reader.sv - SDRAM burst fetch into FIFO, paced DAC playback; DAC_UNDERRUN_CNT_EN adds underrun_cnt
module dac_playback_reader
    import dac_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_valid,
    input  logic [7:0]        rd_data,
    output logic              dac_en,
    output logic [7:0]        dac_data
`ifdef DAC_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int DIV_W  = $clog2(SAMPLE_DIV) + 1;

    dac_state_e        state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d, underrun_q, underrun_d;
    logic              rd_req_q, rd_req_d, burst_q, burst_d, dac_en_q, dac_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        dac_data_q, dac_data_d;
    logic [LEN_W-1:0]  fetch_rem_q, fetch_rem_d;   // bytes not yet requested
    logic [LEN_W-1:0]  keep_rem_q, keep_rem_d;     // bytes still to be written into the FIFO
    logic [LEN_W-1:0]  play_rem_q, play_rem_d;     // samples not yet popped to the DAC
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              strobe, fifo_push, fifo_pop, fifo_empty;
    logic [7:0]        fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
`ifdef DAC_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;
`endif

    dac_sample_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (rd_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Fetch engine, playback pacing and FSM next-state
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        underrun_d  = underrun_q;
        rd_req_d    = rd_req_q;
        rd_addr_d   = rd_addr_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        dac_en_d    = dac_en_q;
        dac_data_d  = dac_data_q;
        fetch_rem_d = fetch_rem_q;
        keep_rem_d  = keep_rem_q;
        play_rem_d  = play_rem_q;
        div_d       = div_q;
`ifdef DAC_UNDERRUN_CNT_EN
        ucnt_d      = ucnt_q;
`endif
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        strobe      = (div_q == '0);

        if (state_q == ST_PREFILL || state_q == ST_PLAY) begin
            // Beats past the requested length pad out the last burst and are dropped
            if (burst_q && rd_valid) begin
                if (keep_rem_q != '0) begin
                    fifo_push  = 1'b1;
                    keep_rem_d = keep_rem_q - LEN_W'(1);
                end
                if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                    burst_d = 1'b0;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            if (rd_req_q) begin
                if (rd_ack) begin
                    rd_req_d    = 1'b0;
                    burst_d     = 1'b1;
                    beat_d      = '0;
                    rd_addr_d   = rd_addr_q + ADDR_W'(BURST_LEN);
                    fetch_rem_d = (fetch_rem_q > LEN_W'(BURST_LEN)) ?
                                  fetch_rem_q - LEN_W'(BURST_LEN) : '0;
                end
            end else if (!burst_q && fetch_rem_q != '0 &&
                         fifo_count <= CNT_W'(FIFO_DEPTH - BURST_LEN)) begin
                // With no burst outstanding nothing is in flight, so free space is depth - occupancy
                rd_req_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    underrun_d  = 1'b0;
`ifdef DAC_UNDERRUN_CNT_EN
                    ucnt_d      = '0;
`endif
                    rd_addr_d   = start_addr;
                    fetch_rem_d = length;
                    keep_rem_d  = length;
                    play_rem_d  = length;
                    burst_d     = 1'b0;
                    beat_d      = '0;
                    div_d       = '0;
                    if (length == '0) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_PREFILL;
                        busy_d   = 1'b1;
                        rd_req_d = 1'b1;
                    end
                end
            end
            ST_PREFILL: begin
                div_d = '0;
                if (fifo_count >= CNT_W'(BURST_LEN) || keep_rem_q == '0) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                div_d = (div_q == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_q + DIV_W'(1);
                if (strobe) begin
                    if (play_rem_q == '0) begin
                        // Last sample has been held for a full slot
                        state_d    = ST_FINISH;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        dac_en_d   = 1'b0;
                        dac_data_d = 8'h00;
                    end else begin
                        dac_en_d = 1'b1;
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            dac_data_d = fifo_dout;
                            play_rem_d = play_rem_q - LEN_W'(1);
                        end else begin
                            dac_data_d = 8'h00;
                            underrun_d = 1'b1;
`ifdef DAC_UNDERRUN_CNT_EN
                            if (ucnt_q != '1) ucnt_d = ucnt_q + UNDERRUN_CNT_W'(1);
`endif
                        end
                    end
                end
            end
            ST_FINISH: begin
                state_d  = ST_IDLE;
                rd_req_d = 1'b0;
                burst_d  = 1'b0;
                beat_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            burst_q     <= 1'b0;
            beat_q      <= '0;
            dac_en_q    <= 1'b0;
            dac_data_q  <= 8'h00;
            fetch_rem_q <= '0;
            keep_rem_q  <= '0;
            play_rem_q  <= '0;
            div_q       <= '0;
`ifdef DAC_UNDERRUN_CNT_EN
            ucnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            dac_en_q    <= dac_en_d;
            dac_data_q  <= dac_data_d;
            fetch_rem_q <= fetch_rem_d;
            keep_rem_q  <= keep_rem_d;
            play_rem_q  <= play_rem_d;
            div_q       <= div_d;
`ifdef DAC_UNDERRUN_CNT_EN
            ucnt_q      <= ucnt_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;
    assign rd_req   = rd_req_q;
    assign rd_addr  = rd_addr_q;
    assign dac_en   = dac_en_q;
    assign dac_data = dac_data_q;
`ifdef DAC_UNDERRUN_CNT_EN
    assign underrun_cnt = ucnt_q;
`endif

endmodule
